// File: rtl/board_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : board_mem_arbiter
// Description : Shares the single-port board BRAM between the renderer
//               (read-only, strict priority) and the life updater
//               (read/write, uses free cycles). Each issued read is tagged
//               with its owner. The returned word goes to that owner's data
//               output, and the owner's valid output pulses for one cycle.
//               Optional macro ARB_STATS_EN adds saturating issue counters
//               rend_cnt_out / upd_cnt_out.
// Ports       : clk_130mhz, rst_in (sync, active-high)
//               rend_req_in/rend_addr_in -> rend_data_out/rend_valid_out
//               upd_req_in/upd_we_in/upd_addr_in/upd_data_in -> upd_gnt_out
//                 (comb.), upd_data_out/upd_valid_out
//               mem_addr_out/mem_we_out/mem_din_out (registered), mem_dout_in
//               starve_out (sticky updater starvation flag)
// Revision    : 1.0 - initial release
// ============================================================================
module board_mem_arbiter #(
    parameter int LOG_MAX_ADDR = 14,
    parameter int WORD_SIZE    = 16,
    parameter int READ_LATENCY = 2,
    parameter int STARVE_LIMIT = 64
) (
    input  logic                    clk_130mhz,
    input  logic                    rst_in,
    input  logic                    rend_req_in,
    input  logic [LOG_MAX_ADDR-1:0] rend_addr_in,
    output logic [WORD_SIZE-1:0]    rend_data_out,
    output logic                    rend_valid_out,
    input  logic                    upd_req_in,
    input  logic                    upd_we_in,
    input  logic [LOG_MAX_ADDR-1:0] upd_addr_in,
    input  logic [WORD_SIZE-1:0]    upd_data_in,
    output logic                    upd_gnt_out,
    output logic [WORD_SIZE-1:0]    upd_data_out,
    output logic                    upd_valid_out,
    output logic [LOG_MAX_ADDR-1:0] mem_addr_out,
    output logic                    mem_we_out,
    output logic [WORD_SIZE-1:0]    mem_din_out,
    input  logic [WORD_SIZE-1:0]    mem_dout_in,
    output logic                    starve_out
`ifdef ARB_STATS_EN
    ,
    output logic [31:0]             rend_cnt_out,
    output logic [31:0]             upd_cnt_out
`endif
);

    // The tag is delayed one stage beyond the BRAM latency. This lines the
    // exit stage up with the cycle in which mem_dout_in holds the word.
    localparam int          c_TAG_STAGES   = READ_LATENCY + 1;
    localparam logic [15:0] c_STARVE_LIMIT = 16'(STARVE_LIMIT);
    localparam logic [15:0] c_STARVE_MAX   = 16'hFFFF;

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_REND = 2'd1,
        TAG_UPD  = 2'd2
    } tag_t;

    // ------------------------------------------------------------------
    // Arbitration (combinational)
    // ------------------------------------------------------------------
    logic w_rend_win;
    logic w_upd_win;
    tag_t w_exit_tag;

    assign w_rend_win  = rend_req_in;
    assign w_upd_win   = upd_req_in & ~rend_req_in;
    // Gated by reset so that no grant is reported for a request that is never issued.
    assign upd_gnt_out = w_upd_win & ~rst_in;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [LOG_MAX_ADDR-1:0] mem_addr_q, mem_addr_d;
    logic                    mem_we_q,   mem_we_d;
    logic [WORD_SIZE-1:0]    mem_din_q,  mem_din_d;
    tag_t                    tag_q [c_TAG_STAGES];
    tag_t                    tag_d [c_TAG_STAGES];
    logic [WORD_SIZE-1:0]    rend_data_q, rend_data_d;
    logic                    rend_valid_q, rend_valid_d;
    logic [WORD_SIZE-1:0]    upd_data_q, upd_data_d;
    logic                    upd_valid_q, upd_valid_d;
    logic [15:0]             starve_cnt_q, starve_cnt_d;
    logic                    starve_q, starve_d;

    assign w_exit_tag = tag_q[c_TAG_STAGES-1];

    always_comb begin
        // Idle issue by default: address and write data hold, no write, no tag
        mem_addr_d = mem_addr_q;
        mem_we_d   = 1'b0;
        mem_din_d  = mem_din_q;
        tag_d[0]   = TAG_NONE;
        for (int i = 1; i < c_TAG_STAGES; i++) begin
            tag_d[i] = tag_q[i-1];
        end

        if (w_rend_win) begin
            mem_addr_d = rend_addr_in;
            tag_d[0]   = TAG_REND;
        end else if (w_upd_win) begin
            mem_addr_d = upd_addr_in;
            mem_we_d   = upd_we_in;
            mem_din_d  = upd_data_in;
            // Writes return nothing, so they carry no owner tag
            tag_d[0]   = upd_we_in ? TAG_NONE : TAG_UPD;
        end

        // Return routing: the tag leaving the pipe names the owner of mem_dout_in
        rend_valid_d = (w_exit_tag == TAG_REND);
        upd_valid_d  = (w_exit_tag == TAG_UPD);
        rend_data_d  = rend_valid_d ? mem_dout_in : rend_data_q;
        upd_data_d   = upd_valid_d  ? mem_dout_in : upd_data_q;

        // Count consecutive denied cycles, saturating at the counter's maximum
        if (upd_req_in && !w_upd_win) begin
            starve_cnt_d = (starve_cnt_q == c_STARVE_MAX) ? starve_cnt_q
                                                          : starve_cnt_q + 16'd1;
        end else begin
            starve_cnt_d = 16'd0;
        end
        starve_d = starve_q | (starve_cnt_d >= c_STARVE_LIMIT);
    end

    always_ff @(posedge clk_130mhz) begin
        if (rst_in) begin
            mem_addr_q   <= '0;
            mem_we_q     <= 1'b0;
            mem_din_q    <= '0;
            for (int i = 0; i < c_TAG_STAGES; i++) begin
                tag_q[i] <= TAG_NONE;
            end
            rend_data_q  <= '0;
            rend_valid_q <= 1'b0;
            upd_data_q   <= '0;
            upd_valid_q  <= 1'b0;
            starve_cnt_q <= 16'd0;
            starve_q     <= 1'b0;
        end else begin
            mem_addr_q   <= mem_addr_d;
            mem_we_q     <= mem_we_d;
            mem_din_q    <= mem_din_d;
            for (int i = 0; i < c_TAG_STAGES; i++) begin
                tag_q[i] <= tag_d[i];
            end
            rend_data_q  <= rend_data_d;
            rend_valid_q <= rend_valid_d;
            upd_data_q   <= upd_data_d;
            upd_valid_q  <= upd_valid_d;
            starve_cnt_q <= starve_cnt_d;
            starve_q     <= starve_d;
        end
    end

    assign mem_addr_out   = mem_addr_q;
    assign mem_we_out     = mem_we_q;
    assign mem_din_out    = mem_din_q;
    assign rend_data_out  = rend_data_q;
    assign rend_valid_out = rend_valid_q;
    assign upd_data_out   = upd_data_q;
    assign upd_valid_out  = upd_valid_q;
    assign starve_out     = starve_q;

`ifdef ARB_STATS_EN
    // ------------------------------------------------------------------
    // Issue statistics, saturating
    // ------------------------------------------------------------------
    localparam logic [31:0] c_CNT_MAX = 32'hFFFF_FFFF;

    logic [31:0] rend_cnt_q, rend_cnt_d;
    logic [31:0] upd_cnt_q,  upd_cnt_d;

    always_comb begin
        rend_cnt_d = rend_cnt_q;
        upd_cnt_d  = upd_cnt_q;
        if (w_rend_win && rend_cnt_q != c_CNT_MAX) begin
            rend_cnt_d = rend_cnt_q + 32'd1;
        end
        if (w_upd_win && upd_cnt_q != c_CNT_MAX) begin
            upd_cnt_d = upd_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_130mhz) begin
        if (rst_in) begin
            rend_cnt_q <= 32'd0;
            upd_cnt_q  <= 32'd0;
        end else begin
            rend_cnt_q <= rend_cnt_d;
            upd_cnt_q  <= upd_cnt_d;
        end
    end

    assign rend_cnt_out = rend_cnt_q;
    assign upd_cnt_out  = upd_cnt_q;
`endif

endmodule
`default_nettype wire
